// File: rtl/rs232_mem_pkg.sv
// Shared definitions for the RS232 memory bank: state encoding, default geometry
// and a constant-friendly ceil(log2) helper.
package rs232_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 14;
    localparam int DEF_DEPTH  = 16384;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    // Bits needed to index 'value' words; never returns less than 1.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/rs232_mem_array.sv
// Plain single-port synchronous RAM with a registered read port; maps onto block RAM.
module rs232_mem_array #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset on purpose; a reset term would stop
    // block-RAM inference, and the controller's init sweep clears it instead.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/rs232_mem_bank.sv
// Memory bank controller: init/clear sweep, request/accept handshake, range check
// and one-cycle read-valid / error strobes around a single-port RAM.
module rs232_mem_bank
    import rs232_mem_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DEPTH   = DEF_DEPTH,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_clear,
    output logic              mem_ready,
    output logic              mem_rd_valid,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_err
);

    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              accept, in_range, sweep_last;
    logic [31:0]       addr_wide;

    logic              arr_we;
    logic [AW-1:0]     arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    logic              rd_valid, err, rd_oor;
    logic [DATA_W-1:0] data_hold;

    assign mem_ready  = (state == ST_IDLE);
    assign accept     = mem_req & mem_ready & ~mem_clear;
    assign addr_wide  = 32'(mem_addr);
    assign in_range   = (addr_wide < 32'(DEPTH));
    assign sweep_last = (cnt == CNT_W'(DEPTH - 1));

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        arr_we    = 1'b0;
        arr_addr  = mem_addr[AW-1:0];
        arr_wdata = mem_data_in;
        case (state)
            ST_INIT: begin
                arr_we    = 1'b1;
                arr_addr  = cnt[AW-1:0];
                arr_wdata = CLR_VAL;
                if (sweep_last) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (mem_clear) begin
                    state_nxt = ST_INIT;
                    cnt_nxt   = '0;
                end else if (accept && mem_write && in_range) begin
                    arr_we = 1'b1;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
        // Reset itself must leave the stored words alone.
        if (rst) begin
            arr_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
            rd_oor    <= 1'b0;
            data_hold <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rd_valid  <= accept & ~mem_write;
            err       <= accept & ~in_range;
            rd_oor    <= ~in_range;
            data_hold <= mem_data_out;
        end
    end

    // The RAM output changes every cycle, so the last read value is held separately.
    assign mem_data_out = rd_valid ? (rd_oor ? '0 : arr_rdata) : data_hold;
    assign mem_rd_valid = rd_valid;
    assign mem_err      = err;

    rs232_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_rs232_mem_bank.sv
// Self-checking bench: two bank instances (16 words / clear A5, and 20 words on a
// 5-bit port) compared every cycle against a word-level behavioural model.
module tb_rs232_mem_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst = 2'b11, req = '0, wr = '0, clr = '0;
    logic [13:0] addr [2];
    logic [7:0]  din  [2];
    logic [1:0]  rdy_o, vld_o, err_o;
    logic [7:0]  dout_o [2];

    rs232_mem_bank #(.DATA_W(8), .ADDR_W(14), .DEPTH(16), .CLR_VAL(8'hA5)) u0 (
        .clk(clk), .rst(rst[0]), .mem_req(req[0]), .mem_write(wr[0]),
        .mem_addr(addr[0]), .mem_data_in(din[0]), .mem_clear(clr[0]),
        .mem_ready(rdy_o[0]), .mem_rd_valid(vld_o[0]), .mem_data_out(dout_o[0]),
        .mem_err(err_o[0]));

    rs232_mem_bank #(.DATA_W(8), .ADDR_W(5), .DEPTH(20), .CLR_VAL(8'h00)) u1 (
        .clk(clk), .rst(rst[1]), .mem_req(req[1]), .mem_write(wr[1]),
        .mem_addr(addr[1][4:0]), .mem_data_in(din[1]), .mem_clear(clr[1]),
        .mem_ready(rdy_o[1]), .mem_rd_valid(vld_o[1]), .mem_data_out(dout_o[1]),
        .mem_err(err_o[1]));

    // Behavioural model: word contents, ready flag, edges spent sweeping, expected strobes.
    int         total = 0, bad = 0;
    int         dep [2] = '{16, 20};
    logic [7:0] cv  [2] = '{8'hA5, 8'h00};
    logic [7:0] mm  [2][32];
    bit         mr  [2], ev [2], ee [2];
    int         sw  [2];
    logic [7:0] ed  [2];

    // Drives one cycle of inputs on instance k, advances the model, waits past the edge.
    task automatic step(input int k, input bit r, input bit q, input bit w,
                        input int a, input logic [7:0] d, input bit c);
        bit inr;
        rst[k] = r; req[k] = q; wr[k] = w; addr[k] = 14'(a); din[k] = d; clr[k] = c;
        inr = (a < dep[k]);
        ev[k] = 1'b0;
        ee[k] = 1'b0;
        if (r) begin
            mr[k] = 1'b0; sw[k] = 0; ed[k] = 8'h00;
        end else if (!mr[k]) begin
            sw[k]++;
            if (sw[k] == dep[k]) begin
                mr[k] = 1'b1;
                for (int i = 0; i < dep[k]; i++) mm[k][i] = cv[k];
            end
        end else if (c) begin
            mr[k] = 1'b0; sw[k] = 0;
        end else if (q) begin
            ee[k] = !inr;
            if (w) begin
                if (inr) mm[k][a] = d;
            end else begin
                ev[k] = 1'b1;
                ed[k] = inr ? mm[k][a] : 8'h00;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(0, 1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 3, 0, 1);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({rdy_o[k], vld_o[k], err_o[k], dout_o[k]} !== 11'b0) begin
                bad++;
                $display("FAIL reset k=%0d got rdy/vld/err/dout=%b/%b/%b/%h want 0/0/0/00",
                         k, rdy_o[k], vld_o[k], err_o[k], dout_o[k]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            total++;
            if (rdy_o[0] !== (i == 16) || vld_o[0] !== 1'b0 || err_o[0] !== 1'b0) begin
                bad++;
                $display("FAIL sweep edge=%0d got rdy/vld/err=%b/%b/%b want %b/0/0",
                         i, rdy_o[0], vld_o[0], err_o[0], (i == 16));
            end
        end
        for (int a = 0; a < 16; a++) begin
            step(0, 0, 1, 0, a, 0, 0);
            total++;
            if (vld_o[0] !== 1'b1 || dout_o[0] !== 8'hA5) begin
                bad++;
                $display("FAIL sweep_read addr=%0d got vld/dout=%b/%h want 1/a5", a, vld_o[0], dout_o[0]);
            end
        end
    endtask

    task automatic test_write_read();
        step(0, 0, 1, 1, 5, 8'h3C, 0);
        step(0, 0, 1, 0, 5, 0, 0);
        total++;
        if (vld_o[0] !== 1'b1 || dout_o[0] !== 8'h3C || err_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL write_read got vld/dout/err=%b/%h/%b want 1/3c/0", vld_o[0], dout_o[0], err_o[0]);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < 4) step(0, 0, 1, 0, $urandom_range(0, 15), 0, 0);
            else       step(0, 0, 0, 0, 0, 0, 0);
            total++;
            if ({rdy_o[0], vld_o[0], err_o[0], dout_o[0]} !== {mr[0], ev[0], ee[0], ed[0]}) begin
                bad++;
                $display("FAIL back_to_back i=%0d got rdy/vld/err/dout=%b/%b/%b/%h want %b/%b/%b/%h",
                         i, rdy_o[0], vld_o[0], err_o[0], dout_o[0], mr[0], ev[0], ee[0], ed[0]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            step(0, 0, ($urandom % 4) != 0, $urandom % 2, $urandom_range(0, 17), 8'($urandom), 0);
            total++;
            if ({rdy_o[0], vld_o[0], err_o[0], dout_o[0]} !== {mr[0], ev[0], ee[0], ed[0]}) begin
                bad++;
                $display("FAIL random i=%0d got rdy/vld/err/dout=%b/%b/%b/%h want %b/%b/%b/%h",
                         i, rdy_o[0], vld_o[0], err_o[0], dout_o[0], mr[0], ev[0], ee[0], ed[0]);
            end
        end
    endtask

    task automatic test_not_ready();
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            if (i <= 10) step(0, 0, 1, 1, 2, 8'h77, 0);
            else         step(0, 0, 0, 0, 0, 0, 0);
            total++;
            if ({rdy_o[0], vld_o[0], err_o[0]} !== {mr[0], 2'b00}) begin
                bad++;
                $display("FAIL not_ready edge=%0d got rdy/vld/err=%b/%b/%b want %b/0/0",
                         i, rdy_o[0], vld_o[0], err_o[0], mr[0]);
            end
        end
        step(0, 0, 1, 0, 2, 0, 0);
        total++;
        if (vld_o[0] !== 1'b1 || dout_o[0] !== 8'hA5) begin
            bad++;
            $display("FAIL not_ready_read got vld/dout=%b/%h want 1/a5", vld_o[0], dout_o[0]);
        end
    endtask

    task automatic test_clear();
        for (int a = 1; a <= 4; a++) step(0, 0, 1, 1, a, 8'($urandom_range(0, 255)), 0);
        step(0, 0, 1, 0, 3, 0, 1);
        total++;
        if (vld_o[0] !== 1'b0 || rdy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL clear_drop got vld/rdy=%b/%b want 0/0", vld_o[0], rdy_o[0]);
        end
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0, 0, 0, i == 3);
            total++;
            if (rdy_o[0] !== mr[0] || vld_o[0] !== 1'b0) begin
                bad++;
                $display("FAIL clear_sweep edge=%0d got rdy/vld=%b/%b want %b/0", i, rdy_o[0], vld_o[0], mr[0]);
            end
        end
        for (int a = 0; a < 16; a++) begin
            step(0, 0, 1, 0, a, 0, 0);
            total++;
            if (vld_o[0] !== 1'b1 || dout_o[0] !== 8'hA5) begin
                bad++;
                $display("FAIL clear_read addr=%0d got vld/dout=%b/%h want 1/a5", a, vld_o[0], dout_o[0]);
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            total++;
            if (rdy_o[0] !== (i == 16)) begin
                bad++;
                $display("FAIL mid_sweep_reset edge=%0d got rdy=%b want %b", i, rdy_o[0], (i == 16));
            end
        end
    endtask

    task automatic test_out_of_range();
        step(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (rdy_o[1] !== 1'b1) begin
            bad++;
            $display("FAIL oor_ready got rdy=%b want 1", rdy_o[1]);
        end
        for (int i = 0; i < 8; i++) step(1, 0, 1, 1, $urandom_range(0, 19), 8'($urandom), 0);
        step(1, 0, 1, 1, 25, 8'h11, 0);
        total++;
        if (err_o[1] !== 1'b1 || vld_o[1] !== 1'b0) begin
            bad++;
            $display("FAIL oor_write got err/vld=%b/%b want 1/0", err_o[1], vld_o[1]);
        end
        step(1, 0, 1, 0, 25, 0, 0);
        total++;
        if (err_o[1] !== 1'b1 || vld_o[1] !== 1'b1 || dout_o[1] !== 8'h00) begin
            bad++;
            $display("FAIL oor_read got err/vld/dout=%b/%b/%h want 1/1/00", err_o[1], vld_o[1], dout_o[1]);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (err_o[1] !== 1'b0 || vld_o[1] !== 1'b0 || dout_o[1] !== 8'h00) begin
            bad++;
            $display("FAIL oor_idle got err/vld/dout=%b/%b/%h want 0/0/00", err_o[1], vld_o[1], dout_o[1]);
        end
        for (int a = 0; a < 22; a++) begin
            step(1, 0, 1, 0, (a < 20) ? a : ((a == 20) ? 20 : 31), 0, 0);
            total++;
            if ({vld_o[1], err_o[1], dout_o[1]} !== {ev[1], ee[1], ed[1]}) begin
                bad++;
                $display("FAIL oor_scan i=%0d got vld/err/dout=%b/%b/%h want %b/%b/%h",
                         a, vld_o[1], err_o[1], dout_o[1], ev[1], ee[1], ed[1]);
            end
        end
    endtask

    initial begin
        addr[0] = '0; addr[1] = '0; din[0] = '0; din[1] = '0;
        test_reset();
        test_sweep();
        test_write_read();
        test_random();
        test_not_ready();
        test_clear();
        test_reset_mid_sweep();
        step(0, 0, 0, 0, 0, 0, 0);
        test_out_of_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs232_mem_bank.md
Name: rs232_mem_bank

Overview:
- Parametrised single-port synchronous memory bank; next generation of the RS232 memory macro used as the receive/transmit data store.
- Generalised data width, address width and depth; clear value configurable.
- Adds a request/accept handshake, a registered read-valid strobe, a ready flag during the initialisation sweep, a run-time clear command, and out-of-range detection.
- Sits between the RS232 command decoder and storage.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 14, address port width in bits.
- DEPTH, 16384, number of words. Legal range is 2..2**ADDR_W.
- CLR_VAL, 0, DATA_W-bit value written to every word by the init sweep.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  in  1  access request, valid this cycle.
- mem_write  in  1  1 = write, 0 = read; qualified by mem_req.
- mem_addr  in  ADDR_W  word address.
- mem_data_in  in  DATA_W  write data.
- mem_clear  in  1  single-cycle pulse; re-runs the init sweep.
- mem_ready  out  1  registered; 1 = IDLE state, requests may be accepted.
- mem_rd_valid  out  1  one-cycle strobe; mem_data_out carries read data.
- mem_data_out  out  DATA_W  last read data, held between reads; never high-Z.
- mem_err  out  1  one-cycle strobe; an out-of-range access was accepted.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at an edge):
  - state<=INIT, sweep counter<=0.
  - mem_ready=0, mem_rd_valid=0, mem_err=0, mem_data_out=0.
  - Memory contents are not touched during reset itself.
- FSM states are INIT and IDLE.
- INIT, at each edge with rst=0:
  - mem[cnt]<=CLR_VAL.
  - If cnt==DEPTH-1: state<=IDLE and mem_ready<=1. Otherwise cnt<=cnt+1.
  - mem_ready first reads 1 after exactly DEPTH edges with rst low.
  - Counter width is clog2(DEPTH)+1. There is no wrap.
- Accept condition: accept = mem_req & mem_ready & ~mem_clear.
  - In INIT, requests are ignored. No state change, no strobes.
  - The requester holds mem_req until it sees mem_ready=1.
- Write (accepted, mem_write=1): mem[mem_addr]<=mem_data_in at the same edge. mem_data_out is unchanged.
- Read (accepted, mem_write=0):
  - Data is latched at the accepting edge.
  - mem_rd_valid=1 and mem_data_out=mem[mem_addr] during the following cycle. Latency is 1.
  - Back-to-back reads give one valid per cycle.
  - A write then a read of the same address on the next cycle returns the new data.
  - Read-during-write in the same cycle cannot occur (single port).
- Out-of-range (mem_addr >= DEPTH, accepted):
  - A write is discarded.
  - A read returns 0 with mem_rd_valid=1.
  - In both cases mem_err=1 in the following cycle.
- mem_clear in IDLE:
  - Next edge: state<=INIT, cnt<=0, mem_ready<=0.
  - A request in the same cycle is dropped.
  - mem_clear in INIT is ignored; the sweep does not restart.
- rst during INIT restarts the sweep from address 0.
- rst has priority over mem_clear and any request.
- mem_rd_valid and mem_err are forced to 0 in any cycle following a non-accepting edge.

Decomposition:
- Package rs232_mem_pkg holds:
  - state encoding (ST_INIT, ST_IDLE);
  - default DATA_W, ADDR_W, DEPTH;
  - a clog2 function.
- One sub-module: rs232_mem_array, a plain single-port synchronous RAM.
  - Ports: we, addr, wdata, rdata.
  - Registered read; infers block RAM.
- The top level owns the FSM, sweep counter, address muxing (sweep vs user), range check and strobes.

Test Plan:
- Reset sweep (DEPTH=16, CLR_VAL=8'hA5): deassert rst, then count edges. Expect mem_ready=1 after exactly 16 edges. Reads of addresses 0..15 return A5 with rd_valid one cycle after each accept.
- Write/read pipeline: write 3C to addr 5, then immediate read of addr 5 on the next cycle. Expect rd_valid the following cycle with data_out=3C. Then 4 back-to-back reads give 4 consecutive rd_valid pulses.
- Not-ready blocking: assert req/write to addr 2 with data 77 during the sweep. Expect no rd_valid and no err; after ready, addr 2 reads CLR_VAL.
- Clear command: with data written, pulse mem_clear together with a read request. Expect the read dropped (no rd_valid), mem_ready low for 16 cycles, then all addresses read CLR_VAL.
- Out-of-range (ADDR_W=5, DEPTH=20): write 11 to addr 25, then read addr 25. Expect err pulse after each; the read returns 0; addresses 0..19 are unchanged.
- Reset mid-sweep: assert rst at sweep count 7 for one cycle. Expect mem_ready after 16 further edges, not 9.
